// File: rtl/ad_wave_rec_if.sv
// ad_wave_rec_if: bundles the ADC, control/status and record-RAM write
// signals of the AD waveform recorder.
//   ad_clk      ADC sample clock (recorder -> ADC)
//   ad_data     ADC output word
//   start       one-cycle arm pulse, force_trig level trigger override
//   trig_level  unsigned trigger threshold, trig_edge 0=rising 1=falling
//   deci_rate   keep 1 of every deci_rate+1 samples
//   wr_en/wr_addr/wr_data  record RAM write port
//   busy/done   capture status
// modport master: CPU/ADC side, modport slave: the recorder.
interface ad_wave_rec_if #(
  parameter int DATA_W = 8,
  parameter int ADDR_W = 8,
  parameter int DECI_W = 16
);
  logic              ad_clk;
  logic [DATA_W-1:0] ad_data;
  logic              start;
  logic              force_trig;
  logic [DATA_W-1:0] trig_level;
  logic              trig_edge;
  logic [DECI_W-1:0] deci_rate;
  logic              wr_en;
  logic [ADDR_W-1:0] wr_addr;
  logic [DATA_W-1:0] wr_data;
  logic              busy;
  logic              done;

  modport master (
    output ad_data, start, force_trig, trig_level, trig_edge, deci_rate,
    input  ad_clk, wr_en, wr_addr, wr_data, busy, done
  );

  modport slave (
    input  ad_data, start, force_trig, trig_level, trig_edge, deci_rate,
    output ad_clk, wr_en, wr_addr, wr_data, busy, done
  );
endinterface

// File: rtl/ad_wave_rec.sv
// ad_wave_rec: ADC capture front end. Generates ad_clk = sys_clk/2, samples
// ad_data on the edge that takes ad_clk from 1 to 0, decimates, waits for a
// level crossing (or force_trig) and writes a 2**ADDR_W deep record into an
// external RAM through the wr_* port.
//   sys_clk  system clock, rising edge
//   rst      synchronous reset, active-high
//   bus      ad_wave_rec_if slave modport (ADC, control, status, RAM port)
module ad_wave_rec #(
  parameter int DATA_W = 8,
  parameter int ADDR_W = 8,
  parameter int DECI_W = 16
) (
  input  logic         sys_clk,
  input  logic         rst,
  ad_wave_rec_if.slave bus
);

  typedef enum logic [1:0] {IDLE, ARM, WAIT_TRIG, CAPTURE} state_t;

  state_t            state_q, state_d;
  logic              ad_clk_q;
  logic [DECI_W-1:0] cnt_q, cnt_d;
  logic [DATA_W-1:0] prev_q, prev_d;
  logic [DATA_W-1:0] wr_data_q, wr_data_d;
  logic [ADDR_W-1:0] wr_addr_q, wr_addr_d;
  logic              wr_en_q, wr_en_d;
  logic              busy_q, busy_d;
  logic              done_q, done_d;

  logic strobe, kept, trig, last, accept;

  // The sample strobe edge is the one where the registered ad_clk is 1.
  // The kept sample is used straight from ad_data on that edge, so the
  // write it produces is registered on the capture edge itself.
  assign strobe = ad_clk_q;
  assign kept   = strobe && (cnt_q == bus.deci_rate);
  assign last   = &wr_addr_q;
  assign accept = (state_q == IDLE) && bus.start;

  // Strict on prev, inclusive on the new sample.
  assign trig = bus.force_trig
              | (~bus.trig_edge & (prev_q < bus.trig_level) & (bus.ad_data >= bus.trig_level))
              | ( bus.trig_edge & (prev_q > bus.trig_level) & (bus.ad_data <= bus.trig_level));

  always_ff @(posedge sys_clk) begin
    if (rst) begin
      state_q   <= IDLE;
      ad_clk_q  <= 1'b0;
      cnt_q     <= '0;
      prev_q    <= '0;
      wr_data_q <= '0;
      wr_addr_q <= '0;
      wr_en_q   <= 1'b0;
      busy_q    <= 1'b0;
      done_q    <= 1'b0;
    end else begin
      state_q   <= state_d;
      ad_clk_q  <= ~ad_clk_q;
      cnt_q     <= cnt_d;
      prev_q    <= prev_d;
      wr_data_q <= wr_data_d;
      wr_addr_q <= wr_addr_d;
      wr_en_q   <= wr_en_d;
      busy_q    <= busy_d;
      done_q    <= done_d;
    end
  end

  always_comb begin
    state_d = state_q;
    unique case (state_q)
      IDLE:      if (bus.start)     state_d = ARM;
      ARM:       if (kept)          state_d = WAIT_TRIG;
      WAIT_TRIG: if (kept && trig)  state_d = CAPTURE;
      CAPTURE:   if (kept && last)  state_d = IDLE;
      default:                      state_d = IDLE;
    endcase
  end

  always_comb begin
    cnt_d     = cnt_q;
    prev_d    = prev_q;
    wr_en_d   = 1'b0;
    wr_data_d = wr_data_q;
    // Address holds during the write pulse and steps on the following edge.
    wr_addr_d = wr_en_q ? wr_addr_q + ADDR_W'(1) : wr_addr_q;
    busy_d    = busy_q;
    done_d    = done_q;

    if (strobe) cnt_d = kept ? '0 : cnt_q + DECI_W'(1);
    if (accept) cnt_d = '0;

    unique case (state_q)
      IDLE: begin
        if (bus.start) begin
          busy_d    = 1'b1;
          done_d    = 1'b0;
          wr_addr_d = '0;
        end
      end
      ARM: begin
        if (kept) prev_d = bus.ad_data;
      end
      WAIT_TRIG: begin
        if (kept) begin
          if (trig) begin
            wr_en_d   = 1'b1;
            wr_data_d = bus.ad_data;
          end else begin
            prev_d = bus.ad_data;
          end
        end
      end
      CAPTURE: begin
        if (kept) begin
          wr_en_d   = 1'b1;
          wr_data_d = bus.ad_data;
          if (last) begin
            busy_d = 1'b0;
            done_d = 1'b1;
          end
        end
      end
      default: ;
    endcase
  end

  assign bus.ad_clk  = ad_clk_q;
  assign bus.wr_en   = wr_en_q;
  assign bus.wr_addr = wr_addr_q;
  assign bus.wr_data = wr_data_q;
  assign bus.busy    = busy_q;
  assign bus.done    = done_q;

endmodule

// File: doc/ad_wave_rec.md
Name: ad_wave_rec

Overview:
Capture-side counterpart of the DA waveform generator. Drives the ADC (AD9280-class, 8-bit) sample clock and registers ADC output words. Decimates the samples, waits for a level-crossing trigger, then writes a fixed-depth record into an external dual-port RAM. The Nios II oscilloscope GUI arms the block and reads the record back.

Parameters:
DATA_W, 8, ADC sample width
ADDR_W, 8, record RAM address width; record depth = 2**ADDR_W (256)
DECI_W, 16, width of decimation ratio input

Ports:
sys_clk  in  1  system clock, all logic on rising edge
rst  in  1  synchronous reset, active-high
ad_clk  out  1  ADC sample clock = sys_clk/2
ad_data  in  DATA_W  ADC output word
start  in  1  one-cycle arm pulse from CPU/GUI
force_trig  in  1  level; treated as trigger condition true while high
trig_level  in  DATA_W  trigger threshold, unsigned
trig_edge  in  1  0 = rising crossing, 1 = falling crossing
deci_rate  in  DECI_W  keep 1 of every deci_rate+1 samples
wr_en  out  1  RAM write enable
wr_addr  out  ADDR_W  RAM write address
wr_data  out  DATA_W  RAM write data
busy  out  1  high from accepted start until record complete
done  out  1  record complete, held until next accepted start

Behaviour:
- Reset (rst=1 at a clock edge): ad_clk=0, wr_en=0, wr_addr=0, wr_data=0, busy=0, done=0, state IDLE, decimation counter=0. Reset mid-capture aborts the capture. No partial done is asserted.
- ad_clk toggles every sys_clk cycle after reset.
- Sample strobe: the cycle in which the registered ad_clk is 1, i.e. the edge that drives ad_clk from 1 to 0. On that edge ad_data is captured into smp. This gives the ADC a full half period of setup.
- Decimation: counter increments on each strobe. A strobe with counter==deci_rate is "kept" and resets the counter to 0. deci_rate=0 keeps every strobe. Counter clears on accepted start. deci_rate is sampled every strobe; software changes it only while idle.
- States:
  - IDLE: start -> ARM; busy<=1, done<=0, wr_addr<=0.
  - ARM: first kept sample loads prev only -> WAIT_TRIG.
  - WAIT_TRIG: on each kept sample, evaluate trig = force_trig OR (trig_edge=0 AND prev<trig_level AND smp>=trig_level) OR (trig_edge=1 AND prev>trig_level AND smp<=trig_level). If trig, write that sample at address 0 and go to CAPTURE; otherwise prev<=smp.
  - CAPTURE: each kept sample is written at the next address.
  - After the write at address 2**ADDR_W-1 -> IDLE with busy<=0 and done<=1 on the same edge.
- Write timing: wr_en is a single-cycle pulse on the cycle after the edge where the kept sample was captured. wr_data is that sample; wr_addr is its address. wr_addr advances after each write and wraps to 0 after the final write. There are no wr_en pulses outside WAIT_TRIG-trigger/CAPTURE.
- start while busy=1: ignored.
- start on the same edge as a completing write: the completion takes effect and the start is ignored.
- force_trig asserted in ARM: ignored until WAIT_TRIG, because prev must be valid.
- Comparisons are unsigned on DATA_W bits. smp==prev==trig_level does not trigger: strict on prev, inclusive on smp.
- Minimum record time = 2*(deci_rate+1)*2**ADDR_W sys_clk cycles after the trigger sample.

Test Plan:
- Reset mid-run: rst high during CAPTURE at write 100 -> next cycle wr_en=0, busy=0, done=0, wr_addr=0; ad_clk restarts at 0 and toggles.
- Rising trigger, deci_rate=0: ramp 0..255 repeating, trig_level=128, start -> first wr_en has wr_addr=0, wr_data=128; then 256 writes of 128..255,0..127; done=1 after write 255; busy falls on the same edge.
- Falling trigger, deci_rate=3: descending ramp 255..0, trig_level=64 -> first write data=64; consecutive writes differ by 4; spacing between writes is 8 sys_clk cycles.
- Force trigger: constant ad_data=0x55, trig_level=0x80, force_trig=1 after ARM -> trigger on first WAIT_TRIG kept sample; 256 writes all 0x55.
- No crossing: constant 0x10, trig_level=0x80, force_trig=0 -> busy stays 1, no wr_en for 10000 cycles; done=0.
- start ignored: start pulsed while busy at write 50 -> addresses continue 51,52,… with no restart. A start in the same cycle as done rising -> ignored, busy=0; a start one cycle later -> re-arms, done clears.
